// File: rtl/datapath_sequencer.sv
// datapath_sequencer: expands one operation request (LOADI, ALU, STORE,
// ALU_STORE) into the multi-cycle control sequence for the register-file /
// ALU / RAM datapath. All outputs are registered from the current state, so
// each control word appears one cycle after the FSM enters its state.
module datapath_sequencer #(
    parameter int unsigned ALU_TIMEOUT = 16,
    parameter logic [4:0]  FS_PASS     = 5'b01000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [1:0] op,
    input  logic [4:0] fs_in,
    input  logic       cin_in,
    input  logic [4:0] dst,
    input  logic [4:0] srcA,
    input  logic [4:0] srcB,
    input  logic       stat,
    input  logic       Cout,
    output logic       busy,
    output logic       done,
    output logic       error,
    output logic       carry,
    output logic       Cin,
    output logic       RegWrite,
    output logic       RAMWrite,
    output logic       MUXSelect,
    output logic       InSelect,
    output logic       ALUstart,
    output logic [4:0] FS,
    output logic [4:0] wrAddr,
    output logic [4:0] rdAddrA,
    output logic [4:0] rdAddrB
);

    typedef enum logic [2:0] {
        S_IDLE, S_LOADW, S_EXEC, S_WB, S_SSETUP, S_SWR, S_DONE, S_ERR
    } state_t;

    typedef enum logic [1:0] {
        OP_LOADI = 2'b00, OP_ALU = 2'b01, OP_STORE = 2'b10, OP_ALU_STORE = 2'b11
    } op_t;

    localparam int unsigned   CW       = $clog2(ALU_TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(ALU_TIMEOUT - 1);

    state_t        r_state, w_next;
    op_t           r_op;
    logic [4:0]    r_fs, r_dst, r_srcA, r_srcB;
    logic          r_cin;
    logic [CW-1:0] r_cnt;
    logic [4:0]    w_ssrc;

    // decoded control word for the current state (registered below)
    logic       w_done, w_error, w_cin, w_regwrite, w_ramwrite, w_insel, w_alustart;
    logic [4:0] w_fs, w_wraddr, w_rda, w_rdb;

    // Store source: STORE reads srcA, ALU_STORE stores its own result (dst)
    assign w_ssrc = (r_op == OP_STORE) ? r_srcA : r_dst;

    // State register, request latches and EXEC wait counter
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_op    <= OP_LOADI;
            r_fs    <= '0;
            r_cin   <= 1'b0;
            r_dst   <= '0;
            r_srcA  <= '0;
            r_srcB  <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_IDLE && start) begin
                r_op   <= op_t'(op);
                r_fs   <= fs_in;
                r_cin  <= cin_in;
                r_dst  <= dst;
                r_srcA <= srcA;
                r_srcB <= srcB;
            end
            if (r_state == S_EXEC) r_cnt <= r_cnt + 1'b1;
            else                   r_cnt <= '0;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    case (op_t'(op))
                        OP_LOADI: w_next = S_LOADW;
                        OP_STORE: w_next = S_SSETUP;
                        default:  w_next = S_EXEC;
                    endcase
                end
            end
            S_LOADW:  w_next = S_DONE;
            S_EXEC: begin
                if (stat)                  w_next = S_WB;
                else if (r_cnt == CNT_LAST) w_next = S_ERR;
            end
            S_WB:     w_next = (r_op == OP_ALU_STORE) ? S_SSETUP : S_DONE;
            S_SSETUP: w_next = S_SWR;
            S_SWR:    w_next = S_DONE;
            default:  w_next = S_IDLE;
        endcase
    end

    // Control word decode per state
    always_comb begin
        w_done     = 1'b0;
        w_error    = 1'b0;
        w_cin      = 1'b0;
        w_regwrite = 1'b0;
        w_ramwrite = 1'b0;
        w_insel    = 1'b0;
        w_alustart = 1'b0;
        w_fs       = '0;
        w_wraddr   = '0;
        w_rda      = '0;
        w_rdb      = '0;
        case (r_state)
            S_LOADW: begin
                w_wraddr   = r_dst;
                w_regwrite = 1'b1;
            end
            S_EXEC: begin
                w_alustart = 1'b1;
                w_fs       = r_fs;
                w_cin      = r_cin;
                w_rda      = r_srcA;
                w_rdb      = r_srcB;
                w_insel    = 1'b1;
            end
            S_WB: begin
                w_fs       = r_fs;
                w_cin      = r_cin;
                w_rda      = r_srcA;
                w_rdb      = r_srcB;
                w_insel    = 1'b1;
                w_wraddr   = r_dst;
                w_regwrite = 1'b1;
            end
            S_SSETUP: begin
                w_fs       = FS_PASS;
                w_rda      = w_ssrc;
                w_alustart = 1'b1;
            end
            S_SWR: begin
                w_fs       = FS_PASS;
                w_rda      = w_ssrc;
                w_alustart = 1'b1;
                w_ramwrite = 1'b1;
            end
            S_DONE:  w_done  = 1'b1;
            S_ERR:   w_error = 1'b1;
            default: ;
        endcase
    end

    // Registered outputs; busy tracks the state being entered so it is exact
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy      <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
            carry     <= 1'b0;
            Cin       <= 1'b0;
            RegWrite  <= 1'b0;
            RAMWrite  <= 1'b0;
            MUXSelect <= 1'b0;
            InSelect  <= 1'b0;
            ALUstart  <= 1'b0;
            FS        <= '0;
            wrAddr    <= '0;
            rdAddrA   <= '0;
            rdAddrB   <= '0;
        end else begin
            busy      <= (w_next != S_IDLE);
            done      <= w_done;
            error     <= w_error;
            if (r_state == S_EXEC && stat) carry <= Cout;
            Cin       <= w_cin;
            RegWrite  <= w_regwrite;
            RAMWrite  <= w_ramwrite;
            MUXSelect <= 1'b0;
            InSelect  <= w_insel;
            ALUstart  <= w_alustart;
            FS        <= w_fs;
            wrAddr    <= w_wraddr;
            rdAddrA   <= w_rda;
            rdAddrB   <= w_rdb;
        end
    end

endmodule

// File: tb/tb_datapath_sequencer.sv
// Directed bench for datapath_sequencer. Cycle 0 is the cycle in which start
// is presented; cycle n is observed 1 ns after the n-th following rising edge.
module tb_datapath_sequencer;

    logic       clk = 1'b0;
    logic       reset, start, cin_in, stat, Cout;
    logic [1:0] op;
    logic [4:0] fs_in, dst, srcA, srcB;
    logic       busy, done, error, carry, Cin, RegWrite, RAMWrite, MUXSelect, InSelect, ALUstart;
    logic [4:0] FS, wrAddr, rdAddrA, rdAddrB;
    logic [29:0] all_outs;

    int unsigned n_vec  = 0;
    int unsigned n_miss = 0;

    datapath_sequencer #(.ALU_TIMEOUT(16), .FS_PASS(5'b01000)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .fs_in(fs_in), .cin_in(cin_in),
        .dst(dst), .srcA(srcA), .srcB(srcB), .stat(stat), .Cout(Cout),
        .busy(busy), .done(done), .error(error), .carry(carry), .Cin(Cin),
        .RegWrite(RegWrite), .RAMWrite(RAMWrite), .MUXSelect(MUXSelect), .InSelect(InSelect),
        .ALUstart(ALUstart), .FS(FS), .wrAddr(wrAddr), .rdAddrA(rdAddrA), .rdAddrB(rdAddrB)
    );

    assign all_outs = {busy, done, error, carry, Cin, RegWrite, RAMWrite, MUXSelect,
                       InSelect, ALUstart, FS, wrAddr, rdAddrA, rdAddrB};

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // present a request in cycle 0 and advance to cycle 1
    task automatic req(input logic [1:0] o, input logic [4:0] f, input logic c,
                       input logic [4:0] d, input logic [4:0] a, input logic [4:0] b);
        op = o; fs_in = f; cin_in = c; dst = d; srcA = a; srcB = b;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    initial begin
        int unsigned alu_hi, err_cnt, err_cyc, wr_cnt, done_cnt;
        reset = 1'b0; start = 1'b0; op = '0; fs_in = '0; cin_in = 1'b0;
        dst = '0; srcA = '0; srcB = '0; stat = 1'b0; Cout = 1'b0;

        // reset state
        #3;
        check("reset_outs", all_outs, 30'd0);
        step(); step();
        check("reset_outs_clk", all_outs, 30'd0);
        reset = 1'b1;
        step();
        check("idle_busy", busy, 1'b0);

        // LOADI to reg 0 then reg 1
        for (int unsigned d = 0; d < 2; d++) begin
            req(2'b00, 5'd0, 1'b0, 5'(d), 5'd0, 5'd0);
            check("loadi_c1_busy", busy, 1'b1);
            check("loadi_c1_rw", RegWrite, 1'b0);
            step();
            check("loadi_c2_rw", RegWrite, 1'b1);
            check("loadi_c2_insel", InSelect, 1'b0);
            check("loadi_c2_wraddr", wrAddr, 5'(d));
            check("loadi_c2_done", done, 1'b0);
            step();
            check("loadi_c3_rw", RegWrite, 1'b0);
            check("loadi_c3_done", done, 1'b1);
            check("loadi_c3_busy", busy, 1'b0);
            step();
            check("loadi_c4_done", done, 1'b0);
        end

        // ALU 01100, A=r0 B=r1 -> r3, stat in third EXEC cycle, Cout=1
        req(2'b01, 5'b01100, 1'b1, 5'd3, 5'd0, 5'd1);
        check("alu_c1_start", ALUstart, 1'b0);
        step();
        check("alu_c2_start", ALUstart, 1'b1);
        check("alu_c2_fs", FS, 5'b01100);
        check("alu_c2_cin", Cin, 1'b1);
        check("alu_c2_rdb", rdAddrB, 5'd1);
        check("alu_c2_insel", InSelect, 1'b1);
        step();
        check("alu_c3_start", ALUstart, 1'b1);
        stat = 1'b1; Cout = 1'b1;
        step();
        stat = 1'b0; Cout = 1'b0;
        check("alu_c4_carry", carry, 1'b1);
        check("alu_c4_rw", RegWrite, 1'b0);
        step();
        check("alu_c5_rw", RegWrite, 1'b1);
        check("alu_c5_wraddr", wrAddr, 5'd3);
        check("alu_c5_insel", InSelect, 1'b1);
        check("alu_c5_start", ALUstart, 1'b0);
        check("alu_c5_fs_held", FS, 5'b01100);
        check("alu_c5_done", done, 1'b0);
        step();
        check("alu_c6_done", done, 1'b1);
        check("alu_c6_rw", RegWrite, 1'b0);
        check("alu_c6_carry", carry, 1'b1);
        step();

        // ALU_STORE 10000 -> r4, stat already high, Cout=0
        stat = 1'b1;
        req(2'b11, 5'b10000, 1'b0, 5'd4, 5'd2, 5'd3);
        step();
        stat = 1'b0;
        check("as_c2_start", ALUstart, 1'b1);
        check("as_c2_fs", FS, 5'b10000);
        check("as_c2_rda", rdAddrA, 5'd2);
        check("as_c2_carry", carry, 1'b0);
        step();
        check("as_c3_rw", RegWrite, 1'b1);
        check("as_c3_wraddr", wrAddr, 5'd4);
        check("as_c3_start", ALUstart, 1'b0);
        step();
        check("as_c4_fs", FS, 5'b01000);
        check("as_c4_rda", rdAddrA, 5'd4);
        check("as_c4_start", ALUstart, 1'b1);
        check("as_c4_wr", {RegWrite, RAMWrite}, 2'b00);
        step();
        check("as_c5_ram", RAMWrite, 1'b1);
        check("as_c5_rw", RegWrite, 1'b0);
        check("as_c5_fs", FS, 5'b01000);
        check("as_c5_rda", rdAddrA, 5'd4);
        check("as_c5_start", ALUstart, 1'b1);
        step();
        check("as_c6_done", done, 1'b1);
        check("as_c6_ram", RAMWrite, 1'b0);
        step();

        // timeout: stat never arrives
        req(2'b01, 5'b00001, 1'b0, 5'd6, 5'd1, 5'd2);
        alu_hi = 0; err_cnt = 0; err_cyc = 0; wr_cnt = 0;
        for (int unsigned c = 1; c <= 24; c++) begin
            if (ALUstart) alu_hi++;
            if (RegWrite || RAMWrite) wr_cnt++;
            if (error) begin err_cnt++; err_cyc = c; end
            step();
        end
        check("to_alustart_cycles", alu_hi, 32'd16);
        check("to_error_pulses", err_cnt, 32'd1);
        check("to_error_cycle", err_cyc, 32'd18);
        check("to_no_writes", wr_cnt, 32'd0);
        check("to_idle", busy, 1'b0);
        check("to_carry_held", carry, 1'b0);

        // STORE r5 with start pulses while busy
        req(2'b10, 5'd0, 1'b0, 5'd0, 5'd5, 5'd0);
        op = 2'b00; dst = 5'd9; start = 1'b1;
        check("st_c1_busy", busy, 1'b1);
        step();
        check("st_c2_start", ALUstart, 1'b1);
        check("st_c2_fs", FS, 5'b01000);
        check("st_c2_rda", rdAddrA, 5'd5);
        check("st_c2_ram", RAMWrite, 1'b0);
        step();
        start = 1'b0;
        check("st_c3_ram", RAMWrite, 1'b1);
        check("st_c3_fs", FS, 5'b01000);
        check("st_c3_rda", rdAddrA, 5'd5);
        check("st_c3_rw", RegWrite, 1'b0);
        step();
        check("st_c4_done", done, 1'b1);
        done_cnt = 0; wr_cnt = 0;
        for (int unsigned c = 0; c < 6; c++) begin
            step();
            if (done) done_cnt++;
            if (RegWrite || busy) wr_cnt++;
        end
        check("st_no_extra_done", done_cnt, 32'd0);
        check("st_no_queued_op", wr_cnt, 32'd0);

        // reset asserted during SWR
        req(2'b10, 5'd0, 1'b0, 5'd0, 5'd7, 5'd0);
        step(); step();
        check("rst_pre_ram", RAMWrite, 1'b1);
        #2 reset = 1'b0;
        #1;
        check("rst_async_ram", RAMWrite, 1'b0);
        check("rst_async_outs", all_outs, 30'd0);
        step();
        check("rst_hold_outs", all_outs, 30'd0);
        reset = 1'b1;
        step();
        req(2'b00, 5'd0, 1'b0, 5'd2, 5'd0, 5'd0);
        step();
        check("rst_next_rw", RegWrite, 1'b1);
        check("rst_next_wraddr", wrAddr, 5'd2);
        step();
        check("rst_next_done", done, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
